km_centroid_update: RTL
=======================

# km_centroid_update

Back end of the K-means colour-quantisation datapath. It consumes the eight per-centroid Manhattan distances and the matching pixel, and labels the pixel with its nearest centroid. It accumulates per-cluster RGB sums and pixel counts. On command, it recomputes all eight centroids with a shared serial divider and presents them on `c_out0..7`, which feed back into the distance block's centroid inputs.

## Interface
Parameters:
- `CNT_W`, default 16: width of each per-cluster pixel counter; the count saturates at 2^CNT_W-1.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous clear of accumulators, counts, `ovf`; aborts an update in progress.
- `d_en` in 1: distances and pixel valid this cycle.
- `d_0..d_7` in 10 each: Manhattan distance to centroids 0..7.
- `px_in` in 24: pixel as {R[23:16], G[15:8], B[7:0]}, aligned with `d_*`.
- `c_ld_en` in 1: load initial centroid; accepted only when idle.
- `c_ld_idx` in 3: index of the centroid to load.
- `c_ld_data` in 24: value of the centroid to load.
- `upd_start` in 1: begin centroid recomputation; ignored while `busy`.
- `label` out 3: registered argmin index.
- `label_valid` out 1: one-cycle pulse, one cycle after `d_en`.
- `c_out0..c_out7` out 24 each: current centroids.
- `busy` out 1: update in progress.
- `c_valid` out 1: one-cycle pulse when the update has completed.
- `ovf` out 1: sticky flag; a sample was dropped.

## Operation
- Reset (`rst`=0): all outputs, accumulators, counts and FSM state are 0 (`c_out*`=24'h0, FSM in IDLE).
- Argmin:
  - Strict less-than compare over `d_0..d_7`; ties resolve to the lowest index.
  - Computed combinationally and registered into `label`.
- Accumulate (`d_en`=1, IDLE, `clear`=0):
  - For k=`label` (the combinational argmin): `sum_k.{R,G,B}` += the corresponding `px_in` channel and `cnt_k` += 1.
  - Each sum channel is SUM_W = 8+CNT_W bits.
  - If `cnt_k` is already all-ones, the sample is dropped (sums unchanged) and `ovf` is set.
- `d_en` while `busy`: the label is still produced, nothing is accumulated, and `ovf` is set.
- `c_ld_en` while IDLE writes `c_out[c_ld_idx]` = `c_ld_data`. If `c_ld_en` and `upd_start` arrive in the same cycle, the load wins and the start is ignored.
- FSM states:
  - IDLE: `upd_start` → LOAD, with slot index s=0.
  - LOAD: one cycle; latch the dividend `sum_{s/3}`, channel s%3 (R,G,B order), and the divisor `cnt_{s/3}`. Go to DIV.
  - DIV: SUM_W cycles of restoring division, MSB-first. When s=23 go to DONE; otherwise s+1 and go to LOAD.
  - DONE: one cycle; pulse `c_valid`, zero all sums, counts and `ovf`, return to IDLE.
- Division result:
  - The quotient is floor(sum/cnt), which always fits in 8 bits. It is written into the matching channel of `c_out[s/3]` at the end of that slot's DIV.
  - If `cnt`=0, the slot still takes full time and the channel is not written, so the centroid is retained.
- `clear` in any state: next state is IDLE, with no `c_valid`. Channels already written by the aborted update keep their new values.
- `clear` has priority over `d_en`, `c_ld_en` and `upd_start`.

## Timing
- `label` and `label_valid` are valid in the cycle after the `d_en` edge. Accumulators update on that same edge.
- Each slot is 1+SUM_W cycles, so 25 cycles at the default width. An update is 24 slots, 600 cycles at the default width.
- `upd_start` sampled at edge E:
  - `busy`=1 after edge E.
  - `busy`=0 and `c_valid`=1 after edge E+601 (default width).
- A new `upd_start` is accepted in the cycle `c_valid` is high.

## Configuration
- `KM_ROUND_NEAREST_EN` defined: the LOAD dividend is `sum` + (`cnt`>>1), giving round-half-up. This never exceeds SUM_W bits.
- `KM_ROUND_NEAREST_EN` undefined: truncation (floor).
- Latency is identical in both cases.

## Structure
- Package `km_pkg` holds:
  - constants `KM_K`=8, `RGB_W`=24, `CH_W`=8, `D_W`=10, `NUM_SLOTS`=24;
  - FSM state enum `km_upd_state_t` (IDLE, LOAD, DIV, DONE);
  - a function computing SUM_W from `CNT_W`.
- Sub-module `km_seq_divider`: a restoring serial divider with `start`/`done` and parameterised dividend/divisor widths. One instance is shared across all slots.

## Test plan
- Reset: hold `rst`=0 with random inputs → all outputs 0. Release `rst` → `busy`=0, `c_out*`=0.
- Argmin tie: `d_*`={9,3,3,7,1023,…}, `d_en`=1 → next cycle `label`=1, `label_valid`=1.
- Update:
  - Stimulus: load `c_out4`=24'hABCDEF; send pixels 24'h102030 and 24'h122232 with `d_0`=0 and all others 1023; then `upd_start`.
  - Response: `busy` for 601 cycles, then a `c_valid` pulse; `c_out0`=24'h112131, `c_out4`=24'hABCDEF (cnt=0), counts reset to zero.
- Rounding: pixels 24'h000000 and 24'h010101 to cluster 2, then update → `c_out2`=24'h000000 without `KM_ROUND_NEAREST_EN`, 24'h010101 with it.
- Abort: `clear` 100 cycles into an update → `busy`=0 the next cycle, no `c_valid`, accumulators zero. A subsequent update completes normally.
- Saturation: `CNT_W`=2, four samples to cluster 5 → fourth sample dropped, `ovf`=1. Update gives the average of the first three pixels; `ovf` clears at DONE.

Source files
------------

// File: rtl/km_pkg.sv
// Shared constants, update-FSM state type and accumulator width helper for
// the K-means centroid update back end.
package km_pkg;

  localparam int KM_K      = 8;
  localparam int RGB_W     = 24;
  localparam int CH_W      = 8;
  localparam int D_W       = 10;
  localparam int NUM_SLOTS = 24;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DIV,
    DONE
  } km_upd_state_t;

  // A channel sum must hold 255 * (2^cnt_w - 1) without wrapping.
  function automatic int km_sum_w(input int cnt_w);
    return CH_W + cnt_w;
  endfunction

endpackage

// File: rtl/km_seq_divider.sv
// Restoring serial divider, one quotient bit per cycle MSB-first; the first
// bit is produced on the start edge so a DIVIDEND_W-bit divide ends DIVIDEND_W
// edges after start, with done pulsing in the cycle the quotient is final.
module km_seq_divider #(
  parameter int DIVIDEND_W = 24,
  parameter int DIVISOR_W  = 16,
  parameter int QUO_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [QUO_W-1:0]      quotient,
  output logic                  done
);

  localparam int CNT_BITS = $clog2(DIVIDEND_W + 1);

  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d, rem_in;
  logic [DIVIDEND_W-1:0] quo_q, quo_d, quo_in;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d, dvs_in;
  logic [DIVISOR_W:0]    trial;
  logic [DIVISOR_W:0]    diff;
  logic                  step_en;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    step_en = start || (cnt_q != '0);
    rem_in  = start ? '0 : rem_q;
    quo_in  = start ? dividend : quo_q;
    dvs_in  = start ? divisor : dvs_q;
    trial   = {rem_in, quo_in[DIVIDEND_W-1]};
    diff    = trial - {1'b0, dvs_in};

    if (start) begin
      dvs_d = divisor;
      cnt_d = CNT_BITS'(DIVIDEND_W - 1);
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - CNT_BITS'(1);
      done_d = (cnt_q == CNT_BITS'(1));
    end

    if (step_en) begin
      if (trial >= {1'b0, dvs_in}) begin
        rem_d = diff[DIVISOR_W-1:0];
        quo_d = {quo_in[DIVIDEND_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DIVISOR_W-1:0];
        quo_d = {quo_in[DIVIDEND_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    quo_q <= quo_d;
    dvs_q <= dvs_d;
  end

  assign quotient = quo_q[QUO_W-1:0];
  assign done     = done_q;

endmodule

// File: rtl/km_centroid_update.sv
// K-means back end: argmin labelling, per-cluster accumulation and serial
// centroid recomputation. Define KM_ROUND_NEAREST_EN for round-half-up means.
module km_centroid_update
  import km_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             d_en,
  input  logic [D_W-1:0]   d_0,
  input  logic [D_W-1:0]   d_1,
  input  logic [D_W-1:0]   d_2,
  input  logic [D_W-1:0]   d_3,
  input  logic [D_W-1:0]   d_4,
  input  logic [D_W-1:0]   d_5,
  input  logic [D_W-1:0]   d_6,
  input  logic [D_W-1:0]   d_7,
  input  logic [RGB_W-1:0] px_in,
  input  logic             c_ld_en,
  input  logic [2:0]       c_ld_idx,
  input  logic [RGB_W-1:0] c_ld_data,
  input  logic             upd_start,
  output logic [2:0]       label,
  output logic             label_valid,
  output logic [RGB_W-1:0] c_out0,
  output logic [RGB_W-1:0] c_out1,
  output logic [RGB_W-1:0] c_out2,
  output logic [RGB_W-1:0] c_out3,
  output logic [RGB_W-1:0] c_out4,
  output logic [RGB_W-1:0] c_out5,
  output logic [RGB_W-1:0] c_out6,
  output logic [RGB_W-1:0] c_out7,
  output logic             busy,
  output logic             c_valid,
  output logic             ovf
);

  localparam int SUM_W = km_sum_w(CNT_W);

  km_upd_state_t    state_q, state_d;
  logic [2:0]       slot_k_q, slot_k_d;
  logic [1:0]       slot_ch_q, slot_ch_d;
  logic [2:0]       label_q, label_d;
  logic             label_valid_q, label_valid_d;
  logic             c_valid_q, c_valid_d;
  logic             ovf_q, ovf_d;
  logic [SUM_W-1:0] sum_q [KM_K][3];
  logic [SUM_W-1:0] sum_d [KM_K][3];
  logic [CNT_W-1:0] cnt_q [KM_K];
  logic [CNT_W-1:0] cnt_d [KM_K];
  logic [RGB_W-1:0] c_out_q [KM_K];
  logic [RGB_W-1:0] c_out_d [KM_K];

  logic [D_W-1:0]   d_arr [KM_K];
  logic [D_W-1:0]   amin_val;
  logic [2:0]       amin_idx;
  logic [SUM_W-1:0] div_dividend;
  logic [CNT_W-1:0] div_divisor;
  logic             div_start;
  logic [CH_W-1:0]  div_quo;
  logic             div_done;

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    d_arr[0] = d_0;  d_arr[1] = d_1;  d_arr[2] = d_2;  d_arr[3] = d_3;
    d_arr[4] = d_4;  d_arr[5] = d_5;  d_arr[6] = d_6;  d_arr[7] = d_7;
    amin_idx = 3'd0;
    amin_val = d_arr[0];
    for (int i = 1; i < KM_K; i++) begin
      if (d_arr[i] < amin_val) begin
        amin_val = d_arr[i];
        amin_idx = 3'(i);
      end
    end
  end

  always_comb begin
    div_dividend = sum_q[slot_k_q][slot_ch_q];
    div_divisor  = cnt_q[slot_k_q];
`ifdef KM_ROUND_NEAREST_EN
    div_dividend = div_dividend + SUM_W'(cnt_q[slot_k_q] >> 1);
`endif
  end

  km_seq_divider #(
    .DIVIDEND_W(SUM_W),
    .DIVISOR_W (CNT_W),
    .QUO_W     (CH_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst),
    .start   (div_start),
    .dividend(div_dividend),
    .divisor (div_divisor),
    .quotient(div_quo),
    .done    (div_done)
  );

  always_comb begin
    state_d       = state_q;
    slot_k_d      = slot_k_q;
    slot_ch_d     = slot_ch_q;
    label_d       = amin_idx;
    label_valid_d = d_en;
    c_valid_d     = 1'b0;
    ovf_d         = ovf_q;
    sum_d         = sum_q;
    cnt_d         = cnt_q;
    c_out_d       = c_out_q;
    div_start     = 1'b0;

    if (clear) begin
      state_d = IDLE;
      ovf_d   = 1'b0;
      for (int k = 0; k < KM_K; k++) begin
        cnt_d[k] = '0;
        for (int c = 0; c < 3; c++) sum_d[k][c] = '0;
      end
    end else begin
      if (d_en && state_q != IDLE) ovf_d = 1'b1;
      unique case (state_q)
        IDLE: begin
          if (d_en) begin
            if (&cnt_q[amin_idx]) begin
              ovf_d = 1'b1;
            end else begin
              sum_d[amin_idx][0] = sum_q[amin_idx][0] + SUM_W'(px_in[23:16]);
              sum_d[amin_idx][1] = sum_q[amin_idx][1] + SUM_W'(px_in[15:8]);
              sum_d[amin_idx][2] = sum_q[amin_idx][2] + SUM_W'(px_in[7:0]);
              cnt_d[amin_idx]    = cnt_q[amin_idx] + CNT_W'(1);
            end
          end
          if (c_ld_en) begin
            c_out_d[c_ld_idx] = c_ld_data;
          end else if (upd_start) begin
            state_d   = LOAD;
            slot_k_d  = 3'd0;
            slot_ch_d = 2'd0;
          end
        end
        LOAD: begin
          div_start = 1'b1;
          state_d   = DIV;
        end
        DIV: begin
          if (div_done) begin
            // An empty cluster keeps its previous centroid channel.
            if (cnt_q[slot_k_q] != '0) begin
              case (slot_ch_q)
                2'd0:    c_out_d[slot_k_q][23:16] = div_quo;
                2'd1:    c_out_d[slot_k_q][15:8]  = div_quo;
                default: c_out_d[slot_k_q][7:0]   = div_quo;
              endcase
            end
            if (slot_k_q == 3'(KM_K - 1) && slot_ch_q == 2'd2) begin
              state_d = DONE;
            end else begin
              state_d = LOAD;
              if (slot_ch_q == 2'd2) begin
                slot_ch_d = 2'd0;
                slot_k_d  = slot_k_q + 3'd1;
              end else begin
                slot_ch_d = slot_ch_q + 2'd1;
              end
            end
          end
        end
        DONE: begin
          c_valid_d = 1'b1;
          ovf_d     = 1'b0;
          state_d   = IDLE;
          for (int k = 0; k < KM_K; k++) begin
            cnt_d[k] = '0;
            for (int c = 0; c < 3; c++) sum_d[k][c] = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      slot_k_q      <= '0;
      slot_ch_q     <= '0;
      label_q       <= '0;
      label_valid_q <= 1'b0;
      c_valid_q     <= 1'b0;
      ovf_q         <= 1'b0;
      for (int k = 0; k < KM_K; k++) begin
        cnt_q[k]   <= '0;
        c_out_q[k] <= '0;
        for (int c = 0; c < 3; c++) sum_q[k][c] <= '0;
      end
    end else begin
      state_q       <= state_d;
      slot_k_q      <= slot_k_d;
      slot_ch_q     <= slot_ch_d;
      label_q       <= label_d;
      label_valid_q <= label_valid_d;
      c_valid_q     <= c_valid_d;
      ovf_q         <= ovf_d;
      cnt_q         <= cnt_d;
      c_out_q       <= c_out_d;
      sum_q         <= sum_d;
    end
  end

  assign label       = label_q;
  assign label_valid = label_valid_q;
  assign busy        = (state_q != IDLE);
  assign c_valid     = c_valid_q;
  assign ovf         = ovf_q;
  assign c_out0      = c_out_q[0];
  assign c_out1      = c_out_q[1];
  assign c_out2      = c_out_q[2];
  assign c_out3      = c_out_q[3];
  assign c_out4      = c_out_q[4];
  assign c_out5      = c_out_q[5];
  assign c_out6      = c_out_q[6];
  assign c_out7      = c_out_q[7];

endmodule
